// File: rtl/counter_mod6.sv
// Modulo-6 loadable down-counter for the tens-of-seconds digit of the cooking timer.
// Build option: COUNTER_MOD6_LOAD_CLAMP_EN clamps out-of-range loads to 5 instead of ignoring them.
module counter_mod6 (
    input  logic       clock,
    input  logic       clr,
    input  logic       loadn,
    input  logic       enable,
    input  logic [3:0] data,
    output logic [3:0] tens,
    output logic       zero,
    output logic       tc
);

    logic [2:0] count;
    logic [2:0] load_value;
    logic       load_take;
    logic       data_ok;

    assign data_ok = (data <= 4'd5);

`ifdef COUNTER_MOD6_LOAD_CLAMP_EN
    assign load_take  = 1'b1;
    assign load_value = data_ok ? data[2:0] : 3'd5;
`else
    // An out-of-range preset leaves the digit untouched; the load cycle still blocks counting.
    assign load_take  = data_ok;
    assign load_value = data[2:0];
`endif

    always_ff @(posedge clock) begin
        if (clr) begin
            count <= 3'd0;
        end else if (!loadn) begin
            if (load_take) begin
                count <= load_value;
            end
        end else if (enable) begin
            if (count == 3'd0) begin
                count <= 3'd5;
            end else begin
                count <= count - 3'd1;
            end
        end
    end

    assign tens = {1'b0, count};
    assign zero = (count == 3'd0);
    // Borrow to the minutes stage on the same edge that this digit wraps 0 -> 5.
    assign tc   = enable & zero;

endmodule

// File: tb/tb_counter_mod6.sv
// Self-checking bench for counter_mod6: directed vector table, hand sequences, random vs. arithmetic model.
module tb_counter_mod6;

    logic       clock;
    logic       clr;
    logic       loadn;
    logic       enable;
    logic [3:0] data;
    logic [3:0] tens;
    logic       zero;
    logic       tc;

    int vectors;
    int miscompares;
    logic [3:0] exp_q[$];

`ifdef COUNTER_MOD6_LOAD_CLAMP_EN
    localparam int CLAMP = 1;
`else
    localparam int CLAMP = 0;
`endif

    typedef struct {
        logic       clr;
        logic       loadn;
        logic       enable;
        logic [3:0] data;
        logic       chk_tc;
        logic       exp_tc;
        logic [3:0] exp_tens;
    } vec_t;

    vec_t vec_q[$];

    counter_mod6 dut (
        .clock  (clock),
        .clr    (clr),
        .loadn  (loadn),
        .enable (enable),
        .data   (data),
        .tens   (tens),
        .zero   (zero),
        .tc     (tc)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic c, input logic l, input logic e, input logic [3:0] d);
        clr    = c;
        loadn  = l;
        enable = e;
        data   = d;
    endtask

    task automatic edge_settle();
        @(posedge clock);
        #1;
    endtask

    task automatic add_vec(input logic c, input logic l, input logic e, input logic [3:0] d,
                           input logic chk, input logic etc, input logic [3:0] et);
        vec_t v;
        v.clr = c; v.loadn = l; v.enable = e; v.data = d;
        v.chk_tc = chk; v.exp_tc = etc; v.exp_tens = et;
        vec_q.push_back(v);
    endtask

    task automatic run_table();
        foreach (vec_q[i]) begin
            drive(vec_q[i].clr, vec_q[i].loadn, vec_q[i].enable, vec_q[i].data);
            #1;
            if (vec_q[i].chk_tc) check($sformatf("tbl%0d_tc", i), {3'b0, tc}, {3'b0, vec_q[i].exp_tc});
            edge_settle();
            check($sformatf("tbl%0d_tens", i), tens, vec_q[i].exp_tens);
            check($sformatf("tbl%0d_zero", i), {3'b0, zero}, {3'b0, (vec_q[i].exp_tens == 4'd0)});
        end
    endtask

    initial begin
        int m;
        int seq[13];
        vectors     = 0;
        miscompares = 0;
        drive(1'b0, 1'b1, 1'b0, 4'd0);
        @(negedge clock);

        // reset, then enable raised without an edge must assert tc immediately
        add_vec(1, 1, 0, 0, 0, 0, 0);
        add_vec(0, 1, 0, 0, 1, 0, 0);
        run_table();
        vec_q.delete();
        enable = 1'b1;
        #1;
        check("reset_tc_no_edge", {3'b0, tc}, 4'd1);
        check("reset_zero", {3'b0, zero}, 4'd1);
        enable = 1'b0;
        #1;
        check("reset_tc_low", {3'b0, tc}, 4'd0);

        // load 4 then 13 enabled edges; expected digits from modular arithmetic
        add_vec(0, 0, 0, 4, 1, 0, 4);
        seq[0] = 4;
        for (int k = 1; k < 13; k++) seq[k] = (seq[k-1] + 5) % 6;
        for (int k = 0; k < 13; k++)
            add_vec(0, 1, 1, 0, 1, (seq[k] == 0), 4'((seq[k] + 5) % 6));
        // priority: load beats count, clr beats load
        add_vec(0, 0, 1, 1, 1, 0, 1);
        add_vec(1, 0, 1, 5, 1, 0, 0);
        // load with enable at zero: load wins but tc still follows enable & zero
        add_vec(0, 0, 1, 3, 1, 1, 3);
        // hold at 2
        add_vec(0, 0, 0, 2, 1, 0, 2);
        for (int k = 0; k < 5; k++) add_vec(0, 1, 0, 0, 1, 0, 2);
        // out-of-range load from 3
        add_vec(0, 0, 0, 3, 1, 0, 3);
        add_vec(0, 0, 1, 9, 1, 0, (CLAMP != 0) ? 4'd5 : 4'd3);
        add_vec(0, 0, 0, 15, 1, 0, (CLAMP != 0) ? 4'd5 : 4'd3);
        // mid-count clear, then wrap with borrow
        add_vec(0, 0, 0, 5, 1, 0, 5);
        add_vec(0, 1, 1, 0, 1, 0, 4);
        add_vec(0, 1, 1, 0, 1, 0, 3);
        add_vec(0, 1, 1, 0, 1, 0, 2);
        add_vec(1, 1, 1, 7, 1, 0, 0);
        add_vec(0, 1, 1, 0, 1, 1, 5);
        // clr while tens is zero and enable high: tc still asserted
        add_vec(1, 1, 0, 0, 1, 0, 0);
        add_vec(1, 0, 1, 4, 1, 1, 0);
        run_table();

        // randomized stimulus against an arithmetic model of the digit
        m = 0;
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 5) != 0),
                  ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
            #1;
            check("rnd_tc", {3'b0, tc}, {3'b0, (enable && m == 0)});
            check("rnd_zero_pre", {3'b0, zero}, {3'b0, (m == 0)});
            if (clr) m = 0;
            else if (!loadn) begin
                if (data <= 5) m = int'(data);
                else if (CLAMP != 0) m = 5;
            end else if (enable) m = (m + 5) % 6;
            exp_q.push_back(4'(m));
            edge_settle();
            check("rnd_tens", tens, exp_q.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/counter_mod6.md
# counter_mod6

Modulo-6 loadable down-counter producing the tens-of-seconds digit (0–5) of the microwave cooking timer. It sits between the seconds-units counter and the minutes counter. It decrements once per enabled clock, wraps 0→5, and flags zero and terminal-count (borrow) so the minutes stage can decrement.

## Interface
Parameters: none.

Ports:
- `clock` in 1: single system clock; all state changes on the rising edge.
- `clr` in 1: reset, synchronous, active-high; forces `tens` to 0.
- `loadn` in 1: synchronous parallel load, active-low.
- `enable` in 1: count-down enable, active-high; driven by the units-stage borrow.
- `data` in 4: BCD preset value for load.
- `tens` out 4: current digit, registered, range 0–5.
- `zero` out 1: high when `tens` == 0; combinational from the register.
- `tc` out 1: terminal count/borrow; `enable` AND (`tens` == 0); combinational.

## Operation
Register update priority on each rising edge of `clock`, highest first:
1. `clr`=1: `tens` ← 0.
2. `loadn`=0: `tens` ← `data` when `data` ≤ 5. For `data` > 5, behaviour depends on the configuration macro.
3. `enable`=1: if `tens` = 0 then `tens` ← 5, else `tens` ← `tens` − 1.
4. Otherwise: hold.

Output rules:
- `tens` never leaves 0–5. The upper bits are the zero-extended count; `tens[3]` is always 0.
- `zero` = (`tens` == 4'd0). It is independent of `enable`, `loadn` and `clr` inputs.
- `tc` = `enable` & `zero`. It is asserted during the cycle in which the counter wraps 0→5, so the next stage decrements on the same edge.
- Load overrides count. `tc` still follows `enable` & `zero` combinationally during a load cycle; the downstream stage decides whether to qualify it.
- `clr` overrides load and count. `tc` can still be 1 during a `clr` cycle if `tens` is currently 0 and `enable` is 1.

## Timing
- Load latency 1 cycle: `data` appears on `tens` after the edge at which `loadn` is sampled low.
- Count latency 1 cycle per decrement. One full cycle of 6 enabled edges returns the counter to its start value.
- Reset: after the edge with `clr`=1, `tens`=0 and `zero`=1. `tc` equals the current `enable`.
- Before the first reset or load, `tens` is undefined. Benches must apply `clr` or `loadn` first.
- `zero` and `tc` change only after `clock` edges or `enable` changes. There is no combinational path from `data`, `loadn` or `clr`.
- Boundary conditions:
  - `enable` held high at `tens`=0 wraps to 5 with `tc`=1 for exactly that cycle.
  - `loadn`=0 and `enable`=1 together: the load wins and no decrement occurs.
  - `clr` asserted mid-count returns to 0 on the next edge regardless of other inputs.

## Configuration
Macro `COUNTER_MOD6_LOAD_CLAMP_EN` controls how out-of-range loads (`data` > 5) are handled.
- Defined: an out-of-range `data` is loaded as 5, and the load takes effect.
- Undefined: an out-of-range load is ignored and `tens` holds its previous value. A simultaneous `enable` still does not decrement, because the load cycle retains priority.
- In-range behaviour is identical in both builds.

## Test plan
- Reset: `clr`=1 for one edge, `enable`=0 → `tens`=0, `zero`=1, `tc`=0. Raise `enable` → `tc`=1 with no edge needed.
- Load and count: `data`=4, `loadn`=0 for one edge, then `loadn`=1, `enable`=1 for 13 edges → `tens` sequence 4,3,2,1,0,5,4,3,2,1,0,5,4. `tc`=1 only while `tens`=0. `zero`=1 only while `tens`=0.
- Priority: `tens`=3, `loadn`=0, `data`=1, `enable`=1 → `tens`=1. Then `clr`=1, `loadn`=0, `data`=5 → `tens`=0.
- Hold: `tens`=2, `enable`=0, `loadn`=1 for 5 edges → `tens` stays 2, `zero`=0, `tc`=0.
- Out-of-range load, `tens`=3, `data`=9, `loadn`=0 → `tens`=5 with the macro defined; `tens`=3 without it.
- Mid-count reset: counting from 5 with `enable`=1, assert `clr` when `tens`=2 → `tens`=0 next edge. With `clr` released and `enable` still high, the following edge gives `tens`=5 with `tc`=1 in the preceding cycle.
